// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register map, line count and id width.
package irq_ctrl_pkg;

    localparam int N_IRQ_DEF = 6;
    localparam int ID_W      = 3;

    localparam logic [7:0] OFF_PEND  = 8'h00;
    localparam logic [7:0] OFF_MASK  = 8'h04;
    localparam logic [7:0] OFF_EDGE  = 8'h08;
    localparam logic [7:0] OFF_CUR   = 8'h0C;
    localparam logic [7:0] OFF_CLAIM = 8'h10;
    localparam logic [7:0] OFF_EOI   = 8'h14;
    localparam logic [7:0] OFF_ISR   = 8'h18;

endpackage

// File: rtl/irq_prio_sel.sv
// Fixed-priority selector: the lowest-index eligible line wins.
module irq_prio_sel
    import irq_ctrl_pkg::*;
#(
    parameter int N = N_IRQ_DEF
) (
    input  logic [N-1:0]    eligible,
    output logic [ID_W-1:0] id,
    output logic            valid
);

    always_comb begin
        id    = '0;
        valid = 1'b0;
        // Walk from the top so the lowest set index is the last assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                id    = ID_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Programmable interrupt controller: latches device requests, applies mask, priority
// and in-service nesting, and drives a registered one-hot HWInt to CP0.
module irq_controller
    import irq_ctrl_pkg::*;
#(
    parameter int N_IRQ = N_IRQ_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       Addr,
    input  logic             WE,
    input  logic [31:0]      Din,
    output logic [31:0]      Dout,
    input  logic [N_IRQ-1:0] IRQ,
    output logic [5:0]       HWInt
);

    logic [N_IRQ-1:0] pend_q, mask_q, edge_q, isr_q, prev_q;
    logic [5:0]       hwint_q;

    logic             wr_pend, wr_mask, wr_edge, wr_claim, wr_eoi;
    logic [N_IRQ-1:0] claim_oh, eoi_oh, mode_chg, rise, pend_clr, pend_d, eligible;
    logic [ID_W-1:0]  sel_id;
    logic             sel_valid;
    logic             unused_bits;

    assign unused_bits = ^{Addr[1:0], Din};

    assign wr_pend  = WE && (Addr[7:2] == OFF_PEND[7:2]);
    assign wr_mask  = WE && (Addr[7:2] == OFF_MASK[7:2]);
    assign wr_edge  = WE && (Addr[7:2] == OFF_EDGE[7:2]);
    assign wr_claim = WE && (Addr[7:2] == OFF_CLAIM[7:2]);
    assign wr_eoi   = WE && (Addr[7:2] == OFF_EOI[7:2]);

    // Ids at or above N_IRQ match no line and therefore do nothing.
    always_comb begin
        claim_oh = '0;
        eoi_oh   = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            claim_oh[i] = wr_claim && (Din[ID_W-1:0] == ID_W'(i));
            eoi_oh[i]   = wr_eoi   && (Din[ID_W-1:0] == ID_W'(i));
        end
    end

    assign mode_chg = wr_edge ? (edge_q ^ Din[N_IRQ-1:0]) : '0;
    assign rise     = IRQ & ~prev_q;
    assign pend_clr = (wr_pend ? Din[N_IRQ-1:0] : '0) | claim_oh;

    // Mode change clears outright; on edge lines a new rise beats W1C/CLAIM.
    always_comb begin
        pend_d = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (mode_chg[i])
                pend_d[i] = 1'b0;
            else if (!edge_q[i])
                pend_d[i] = IRQ[i];
            else
                pend_d[i] = rise[i] | (pend_q[i] & ~pend_clr[i]);
        end
    end

    // A line is blocked by its own or any higher-priority in-service bit.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            eligible[i] = pend_q[i] & mask_q[i];
            for (int j = 0; j <= i; j++) begin
                if (isr_q[j])
                    eligible[i] = 1'b0;
            end
        end
    end

    irq_prio_sel #(.N(N_IRQ)) u_prio_sel (
        .eligible (eligible),
        .id       (sel_id),
        .valid    (sel_valid)
    );

    always_comb begin
        Dout = '0;
        case (Addr[7:2])
            OFF_PEND[7:2]: Dout = 32'(pend_q);
            OFF_MASK[7:2]: Dout = 32'(mask_q);
            OFF_EDGE[7:2]: Dout = 32'(edge_q);
            OFF_CUR[7:2]:  Dout = {sel_valid, {(31 - ID_W){1'b0}}, sel_id};
            OFF_ISR[7:2]:  Dout = 32'(isr_q);
            default:       Dout = '0;
        endcase
    end

    // prev_q tracks IRQ through reset so a line held high across reset does not pend.
    always_ff @(posedge clk) begin
        prev_q <= IRQ;
        if (reset) begin
            pend_q  <= '0;
            mask_q  <= '0;
            edge_q  <= '0;
            isr_q   <= '0;
            hwint_q <= '0;
        end else begin
            pend_q <= pend_d;
            if (wr_mask)
                mask_q <= Din[N_IRQ-1:0];
            if (wr_edge)
                edge_q <= Din[N_IRQ-1:0];
            isr_q   <= (isr_q | claim_oh) & ~eoi_oh;
            hwint_q <= sel_valid ? (6'd1 << sel_id) : 6'd0;
        end
    end

    assign HWInt = hwint_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller; expectations are queued when stimulus is applied.
module tb_irq_controller;

    localparam logic [7:0] A_PEND  = 8'h00;
    localparam logic [7:0] A_MASK  = 8'h04;
    localparam logic [7:0] A_EDGE  = 8'h08;
    localparam logic [7:0] A_CUR   = 8'h0C;
    localparam logic [7:0] A_CLAIM = 8'h10;
    localparam logic [7:0] A_EOI   = 8'h14;
    localparam logic [7:0] A_ISR   = 8'h18;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic [5:0]  IRQ;
    logic [5:0]  HWInt;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    irq_controller #(.N_IRQ(6)) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ),
        .HWInt (HWInt)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_mis++;
            $error("FAIL sb_empty: observed 0x%0h expected a queued entry", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, obs, e.val);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        Addr = a;
        Din  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE   = 1'b0;
        Din  = '0;
    endtask

    task automatic chk_rd(input logic [7:0] a);
        Addr = a;
        #1;
        chk(Dout);
    endtask

    task automatic chk_hw();
        chk({26'd0, HWInt});
    endtask

    task automatic do_reset(input logic [5:0] irq_val);
        IRQ   = irq_val;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        Addr  = '0;
        WE    = 1'b0;
        Din   = '0;

        // 1: line 0 held high across reset must not pend once in edge mode
        do_reset(6'b000001);
        reset = 1'b1;
        push("rst_pend", 32'h0);  chk_rd(A_PEND);
        push("rst_mask", 32'h0);  chk_rd(A_MASK);
        push("rst_isr",  32'h0);  chk_rd(A_ISR);
        push("rst_hw",   32'h0);  chk_hw();
        reset = 1'b0;
        wr(A_EDGE, 32'h01);
        wr(A_MASK, 32'h01);
        tick(1);
        push("t1_pend_held", 32'h0); chk_rd(A_PEND);
        push("t1_hw_held",   32'h0); chk_hw();
        IRQ = 6'b000000;
        tick(1);
        IRQ = 6'b000001;
        push("t1_pend_k",  32'h01);
        push("t1_hw_k",    32'h00);
        push("t1_hw_k1",   32'h01);
        tick(1);
        chk_rd(A_PEND);
        chk_hw();
        tick(1);
        chk_hw();

        // 2: level mode, W1C ignored, priority moves when line 2 drops
        do_reset(6'b000000);
        wr(A_MASK, 32'h3F);
        IRQ = 6'b100100;
        push("t2_cur", 32'h8000_0002);
        push("t2_hw",  32'h04);
        tick(1);
        chk_rd(A_CUR);
        tick(1);
        chk_hw();
        wr(A_PEND, 32'h3F);
        push("t2_w1c_pend", 32'h24); chk_rd(A_PEND);
        push("t2_w1c_hw",   32'h04); chk_hw();
        IRQ = 6'b100000;
        push("t2_drop_hw1", 32'h04);
        push("t2_drop_hw2", 32'h20);
        tick(1);
        chk_hw();
        tick(1);
        chk_hw();

        // 3: nesting with claim/EOI
        do_reset(6'b000000);
        wr(A_EDGE, 32'h3F);
        wr(A_MASK, 32'h3F);
        IRQ = 6'b010010;
        tick(2);
        push("t3_hw_l1", 32'h02); chk_hw();
        wr(A_CLAIM, 32'd1);
        tick(1);
        push("t3_claim_hw",   32'h00); chk_hw();
        push("t3_claim_isr",  32'h02); chk_rd(A_ISR);
        push("t3_claim_pend", 32'h10); chk_rd(A_PEND);
        IRQ = 6'b010011;
        tick(2);
        push("t3_l0_hw", 32'h01); chk_hw();
        wr(A_CLAIM, 32'd0);
        tick(1);
        push("t3_claim0_hw", 32'h00); chk_hw();
        wr(A_EOI, 32'd1);
        tick(1);
        push("t3_eoi1_hw",  32'h00); chk_hw();
        push("t3_eoi1_isr", 32'h01); chk_rd(A_ISR);
        wr(A_EOI, 32'd0);
        tick(1);
        push("t3_eoi0_hw", 32'h10); chk_hw();

        // 4: new rising edge beats W1C in the same cycle
        do_reset(6'b000000);
        wr(A_EDGE, 32'h08);
        IRQ = 6'b001000;
        tick(1);
        push("t4_pend_set", 32'h08); chk_rd(A_PEND);
        IRQ = 6'b000000;
        tick(1);
        IRQ = 6'b001000;
        wr(A_PEND, 32'h08);
        push("t4_set_wins", 32'h08); chk_rd(A_PEND);
        wr(A_PEND, 32'h08);
        push("t4_w1c_clear", 32'h00); chk_rd(A_PEND);

        // 5: masking, mode switch clears pend, unmapped read
        do_reset(6'b111111);
        tick(2);
        push("t5_pend_all", 32'h3F); chk_rd(A_PEND);
        push("t5_hw_masked", 32'h00); chk_hw();
        push("t5_cur_masked", 32'h00); chk_rd(A_CUR);
        wr(A_EDGE, 32'h20);
        push("t5_edge_clr", 32'h1F); chk_rd(A_PEND);
        tick(1);
        push("t5_edge_hold", 32'h1F); chk_rd(A_PEND);
        wr(A_EDGE, 32'h00);
        push("t5_lvl_clr", 32'h1F); chk_rd(A_PEND);
        tick(1);
        push("t5_lvl_reload", 32'h3F); chk_rd(A_PEND);
        wr(8'h1C, 32'hFFFF_FFFF);
        push("t5_unmapped", 32'h0); chk_rd(8'h1C);
        push("t5_mask_unchg", 32'h0); chk_rd(A_MASK);

        // 6: out-of-range claim/EOI ids are ignored
        do_reset(6'b000100);
        wr(A_MASK, 32'h3F);
        wr(A_CLAIM, 32'd5);
        tick(1);
        push("t6_hw_base",  32'h04); chk_hw();
        push("t6_isr_base", 32'h20); chk_rd(A_ISR);
        wr(A_CLAIM, 32'd7);
        wr(A_EOI, 32'd6);
        tick(2);
        push("t6_isr_oor", 32'h20);        chk_rd(A_ISR);
        push("t6_hw_oor",  32'h04);        chk_hw();
        push("t6_cur_oor", 32'h8000_0002); chk_rd(A_CUR);
        push("t6_mask_alias", 32'h3F);     chk_rd(8'h07);

        n_cmp++;
        assert (sb.size() == 0) else begin
            n_mis++;
            $error("FAIL sb_drain: observed %0d entries left expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
